// File: rtl/population_spike_counter.sv
// Sums sampled neuron spikes over each simulation step and queues {frame_id, count} in a small FIFO.
// Optional tap on one neuron index is enabled by defining SPIKE_TAP_EN.
module population_spike_counter #(
    parameter int NN           = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int FIFO_AW      = 2,
    parameter int FRAME_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NN+2:0]             neuron_cnt,
    input  logic                      sim_step,
    input  logic                      spike_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAME_W+NN+1:0]     out_data,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic [FIFO_AW:0]          fifo_level
`ifdef SPIKE_TAP_EN
    ,
    input  logic [NN:0]               tap_index,
    output logic                      tap_spike,
    output logic [7:0]                tap_count
`endif
);

    localparam int ACC_W = NN + 2;
    localparam int DW    = FRAME_W + ACC_W;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [1:0] PHASE = 2'(SAMPLE_PHASE);
    // A sample on the boundary edge can only coincide with phase 0, where it opens the new frame.
    localparam bit SPIKE_TO_NEW = (SAMPLE_PHASE == 0);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               primed_q, primed_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [DW-1:0]      last_q, last_d;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [DW-1:0]      mem_d [DEPTH];

    logic               sample, push, pop, full, wr_en, drop;
    logic [ACC_W-1:0]   acc_sum, frame_total, acc_start;

    always_comb begin
        sample  = (neuron_cnt[1:0] == PHASE) && spike_in;
        acc_sum = acc_q + ACC_W'(sample);
        if (SPIKE_TO_NEW) begin
            frame_total = acc_q;
            acc_start   = ACC_W'(sample);
        end else begin
            frame_total = acc_sum;
            acc_start   = '0;
        end

        push  = sim_step && primed_q;
        pop   = (level_q != '0) && out_ready;
        full  = (level_q == (FIFO_AW+1)'(DEPTH));
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;

        acc_d    = sim_step ? acc_start : acc_sum;
        primed_d = primed_q || sim_step;
        frame_d  = push ? frame_q + 1'b1 : frame_q;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {frame_q, frame_total};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            last_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + (FIFO_AW+1)'(wr_en) - (FIFO_AW+1)'(pop);

        // A drop on the same edge as a clear wins so the loss is never hidden.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
        else              ovf_d = ovf_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            frame_q  <= '0;
            primed_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            acc_q    <= acc_d;
            frame_q  <= frame_d;
            primed_q <= primed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

`ifdef SPIKE_TAP_EN
    logic       tap_hit;
    logic       tap_spike_q, tap_spike_d;
    logic [7:0] tap_count_q, tap_count_d;

    always_comb begin
        tap_hit     = sample && (neuron_cnt[NN+2:2] == tap_index);
        tap_spike_d = tap_hit;
        tap_count_d = tap_count_q;
        if (sim_step)
            tap_count_d = (SPIKE_TO_NEW && tap_hit) ? 8'd1 : 8'd0;
        else if (tap_hit && tap_count_q != 8'hFF)
            tap_count_d = tap_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_spike_q <= 1'b0;
            tap_count_q <= 8'd0;
        end else begin
            tap_spike_q <= tap_spike_d;
            tap_count_q <= tap_count_d;
        end
    end

    assign tap_spike = tap_spike_q;
    assign tap_count = tap_count_q;
`endif

endmodule

// File: tb/tb_population_spike_counter.sv
// Randomized bench for population_spike_counter against a queue-based frame model.
module tb_population_spike_counter;

    localparam int NN  = 8;
    localparam int FAW = 2;
    localparam int FW  = 16;
    localparam int AW  = NN + 2;
    localparam int DW  = FW + AW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NN+2:0]  neuron_cnt = '0;
    logic           sim_step = 1'b0;
    logic           spike_in = 1'b0;
    logic           out_ready = 1'b0;
    logic           clr_ovf = 1'b0;
    logic           out_valid;
    logic           overflow;
    logic [DW-1:0]  out_data;
    logic [FAW:0]   fifo_level;
`ifdef SPIKE_TAP_EN
    logic [NN:0]    tap_index = 9'd85;
    logic           tap_spike;
    logic [7:0]     tap_count;
`endif

    population_spike_counter #(.NN(NN), .SAMPLE_PHASE(3), .FIFO_AW(FAW), .FRAME_W(FW)) dut (
        .clk        (clk),
        .reset      (reset),
        .neuron_cnt (neuron_cnt),
        .sim_step   (sim_step),
        .spike_in   (spike_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .fifo_level (fifo_level)
`ifdef SPIKE_TAP_EN
        ,
        .tap_index  (tap_index),
        .tap_spike  (tap_spike),
        .tap_count  (tap_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: frames as whole entries in a bounded queue.
    int            m_acc;
    bit            m_primed;
    int            m_fid;
    logic [DW-1:0] m_q[$];
    bit            m_ovf;
    logic [DW-1:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_primed = 0; m_fid = 0; m_ovf = 0; m_last = '0;
        m_q.delete();
    endfunction

    function automatic void model_edge();
        bit            smp, pop, push, drop;
        logic [DW-1:0] entry;
        smp  = (neuron_cnt[1:0] == 2'd3) && spike_in;
        pop  = (m_q.size() > 0) && out_ready;
        push = 0; drop = 0; entry = '0;
        if (sim_step) begin
            if (m_primed) begin
                push  = 1;
                entry = {m_fid[FW-1:0], AW'(m_acc + int'(smp))};
                m_fid = (m_fid + 1) % 65536;
            end
            m_primed = 1;
            m_acc    = 0;
        end else begin
            m_acc = m_acc + int'(smp);
        end
        if (pop) m_last = m_q.pop_front();
        if (push) begin
            if (m_q.size() < (1 << FAW)) m_q.push_back(entry);
            else drop = 1;
        end
        if (drop) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endfunction

    task automatic compare_all();
        logic [DW-1:0] exp_data;
        exp_data = (m_q.size() > 0) ? m_q[0] : m_last;
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("out_data", 32'(out_data), 32'(exp_data));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    function automatic bit pick(input int mode, input int pct);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic cyc(input bit ss, input int cnt, input bit spk, input bit rdy, input bit clr);
        @(negedge clk);
        sim_step   = ss;
        neuron_cnt = (NN+3)'(cnt);
        spike_in   = spk;
        out_ready  = rdy;
        clr_ovf    = clr;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic body(input int len, input int sm, input int rm);
        for (int i = 1; i < len; i++) cyc(1'b0, i, pick(sm, 50), pick(rm, 60), 1'b0);
    endtask

    task automatic boundary(input int sm, input int rm, input bit clr);
        cyc(1'b1, 0, pick(sm, 50), pick(rm, 60), clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0; sim_step = 1'b0; spike_in = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        do_reset();

        // Silent frames: first boundary only primes, second pushes {0,0}.
        boundary(0, 0, 0);
        body(2048, 0, 0);
        boundary(0, 0, 0);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'd0);
        body(2048, 0, 1);

        // Spike on every slot.
        do_reset();
        boundary(1, 0, 0);
        for (int f = 0; f < 3; f++) begin
            body(2048, 1, 1);
            boundary(1, 0, 0);
            check("all_spike_data", 32'(out_data), {6'd0, 16'(f), 10'd512});
        end
        body(8, 0, 1);

        // Overflow: six frames with no consumer.
        do_reset();
        boundary(2, 0, 0);
        for (int f = 0; f < 6; f++) begin
            body(32, 2, 0);
            boundary(2, 0, 0);
        end
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("drain_fid", 32'(out_data[DW-1:AW]), 32'(k));
            cyc(1'b0, k + 1, 1'b0, 1'b1, 1'b0);
        end
        boundary(0, 0, 0);
        check("next_fid", 32'(out_data[DW-1:AW]), 32'd6);

        // Refill, then full-FIFO push with simultaneous pop, then clear races.
        for (int f = 0; f < 3; f++) boundary(2, 0, 0);
        check("refill_level", 32'(fifo_level), 32'd4);
        cyc(1'b0, 1, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        boundary(0, 1, 0);
        check("full_pop_level", 32'(fifo_level), 32'd4);
        check("full_pop_ovf", 32'(overflow), 32'd0);
        boundary(0, 0, 1);
        check("clr_vs_drop", 32'(overflow), 32'd1);
        cyc(1'b0, 1, 1'b0, 1'b0, 1'b1);
        check("clr_later", 32'(overflow), 32'd0);

        // Random frame lengths, spikes, back-pressure and clears, with a mid-frame reset.
        do_reset();
        for (int f = 0; f < 60; f++) begin
            int len;
            len = $urandom_range(4, 300);
            cyc(1'b1, 0, pick(2, 50), pick(2, 60), ($urandom_range(0, 19) == 0));
            for (int i = 1; i < len; i++)
                cyc(1'b0, i, pick(2, 50), pick(2, 40), ($urandom_range(0, 49) == 0));
            if (f == 30) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
